exe_stage_md: RTL
=================

EXE_STAGE_MD -- requirements
Module: exe_stage_md

Interface
REQ-001 SHALL have parameter: XLEN, 32, datapath width; legal values 32 and 64.
REQ-002 SHALL have parameter: REG_ADDR_WIDTH, 5, register address width.
REQ-003 SHALL have parameter: MD_EN, 1, 1 = iterative multiply/divide unit present; 0 = md_en ignored and treated as 0.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 flush  in  1  kill the in-flight operation and the output slot.
REQ-007 in_valid  in  1 / in_ready  out  1  ID/EXE handshake; transfer when both are high.
REQ-008 pc_exe, rs1_exe, rs2_exe, imm_exe, instr_exe  in  XLEN each  operands and instruction.
REQ-009 rd_addr_exe  in  REG_ADDR_WIDTH  destination register.
REQ-010 forward_mem, forward_wb  in  XLEN each  forwarded results.
REQ-011 a_sel  in  3  select: RS1, PC, ALU (forward_mem), MEM (forward_wb), ZERO; any other code gives 0.
REQ-012 b_sel  in  3  select: RS2, IMM, FOUR, ALU, MEM, ZERO; any other code gives 0.
REQ-013 alu_op  in  4  ALU operation, decoded by the existing alu block.
REQ-014 md_en  in  1 / md_op  in  3  M-extension op, encoded 0-7 as MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
REQ-015 mem_valid  out  1 / mem_ready  in  1  EXE/MEM handshake.
REQ-016 pc_mem, alu_mem, rs2_mem, instr_mem  out  XLEN each / rd_addr_mem  out  REG_ADDR_WIDTH  registered outputs.
REQ-017 busy  out  1  high while the multiply/divide FSM is not IDLE.

Function
REQ-018 SHALL form operand A from a_sel and operand B from b_sel; both muxes are combinational.
REQ-019 SHALL define stall = mem_valid && !mem_ready; in_ready = (state==IDLE) && !stall && !flush.
REQ-020 ALU op (md_en=0) accepted at edge N SHALL present its result on alu_mem with mem_valid=1 after edge N (1-cycle latency).
REQ-021 While stall=1, all *_mem outputs and mem_valid SHALL hold their values.
REQ-022 FSM states SHALL be IDLE, MUL, DIV, DONE.
- IDLE->MUL or IDLE->DIV on accept with md_en=1.
- MUL/DIV -> DONE after exactly XLEN iteration cycles.
- DONE -> IDLE when the result is loaded into the output slot (i.e. !stall).
REQ-023 MUL SHALL use radix-2 shift-add on a 2*XLEN product, with operands sign- or zero-extended per op. MUL returns product[XLEN-1:0]; the other multiply ops return product[2XLEN-1:XLEN].
REQ-024 DIV SHALL be restoring division on magnitudes, with the sign fixed up at DONE. Quotient sign = sign(A) xor sign(B); remainder takes the sign of the dividend.
REQ-025 Divide by zero SHALL return: quotient all ones; remainder = dividend. No exception is raised.
REQ-026 Signed overflow (A = -2^(XLEN-1), B = -1) SHALL return: quotient = A; remainder = 0.
REQ-027 Multiply/divide latency from accept to mem_valid SHALL be XLEN+2 cycles with no stall.
REQ-028 pc, rs2, instr and rd_addr SHALL be captured at accept and held through the iteration.
REQ-029 flush SHALL, at the next edge: clear mem_valid, force the FSM to IDLE, and discard any in-flight result. flush overrides in_valid in the same cycle.
REQ-030 When mem_valid && mem_ready && no new result is available, mem_valid SHALL go to 0 at the next edge.
REQ-031 Back-to-back ALU ops with mem_ready=1 SHALL sustain 1 op per cycle.

Reset
REQ-032 When rst_n=0 (asynchronous), the block SHALL set mem_valid=0, busy=0 and state=IDLE, and clear all *_mem outputs and iteration registers to 0.
REQ-033 in_ready SHALL be 1 in the first cycle after rst_n deasserts, provided mem_valid=0.
REQ-034 rst_n asserted mid-iteration SHALL abandon the operation; no result appears after reset.

Verification
REQ-035 ALU ADD, a_sel=RS1 (5), b_sel=IMM (-3), mem_ready=1 -> next cycle alu_mem=2, mem_valid=1.
REQ-036 a_sel=ALU, forward_mem=0x10, b_sel=MEM, forward_wb=0x20, ADD -> alu_mem=0x30.
REQ-037 MULH, 0x80000000 * 0x80000000 with XLEN=32 -> after 34 cycles alu_mem=0x40000000; busy high for cycles 1-33.
REQ-038 DIV 7 / 0 -> 0xFFFFFFFF. REM 7 / 0 -> 7. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM -7 / 2 -> 0xFFFFFFFF.
REQ-039 mem_ready=0 for 3 cycles while mem_valid=1 -> outputs stable and in_ready=0; the queued op then completes with nothing lost or duplicated.
REQ-040 flush at iteration cycle 10 of DIVU -> next edge: busy=0, mem_valid=0. Asserting rst_n=0 mid-MUL -> all outputs 0 immediately.

Source files
------------

// File: rtl/exe_stage_md_if.sv
// exe_stage_md_if: ID/EXE and EXE/MEM handshake bundle for the execute stage
interface exe_stage_md_if #(
  parameter int XLEN = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      flush;
  logic                      in_valid;
  logic                      in_ready;
  logic [XLEN-1:0]           pc_exe;
  logic [XLEN-1:0]           rs1_exe;
  logic [XLEN-1:0]           rs2_exe;
  logic [XLEN-1:0]           imm_exe;
  logic [XLEN-1:0]           instr_exe;
  logic [REG_ADDR_WIDTH-1:0] rd_addr_exe;
  logic [XLEN-1:0]           forward_mem;
  logic [XLEN-1:0]           forward_wb;
  logic [2:0]                a_sel;
  logic [2:0]                b_sel;
  logic [3:0]                alu_op;
  logic                      md_en;
  logic [2:0]                md_op;
  logic                      mem_valid;
  logic                      mem_ready;
  logic [XLEN-1:0]           pc_mem;
  logic [XLEN-1:0]           alu_mem;
  logic [XLEN-1:0]           rs2_mem;
  logic [XLEN-1:0]           instr_mem;
  logic [REG_ADDR_WIDTH-1:0] rd_addr_mem;
  logic                      busy;
  modport slave (
    input  flush, in_valid, pc_exe, rs1_exe, rs2_exe, imm_exe, instr_exe, rd_addr_exe,
           forward_mem, forward_wb, a_sel, b_sel, alu_op, md_en, md_op, mem_ready,
    output in_ready, mem_valid, pc_mem, alu_mem, rs2_mem, instr_mem, rd_addr_mem, busy
  );
  modport master (
    output flush, in_valid, pc_exe, rs1_exe, rs2_exe, imm_exe, instr_exe, rd_addr_exe,
           forward_mem, forward_wb, a_sel, b_sel, alu_op, md_en, md_op, mem_ready,
    input  in_ready, mem_valid, pc_mem, alu_mem, rs2_mem, instr_mem, rd_addr_mem, busy
  );
endinterface

// File: rtl/exe_stage_md.sv
// exe_stage_md: execute stage with single-cycle ALU and iterative M-extension unit
module exe_stage_md #(
  parameter int XLEN = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MD_EN = 1
) (
  input logic clk,
  input logic rst_n,
  exe_stage_md_if.slave bus
);
  localparam int CW = $clog2(XLEN);
  localparam int W2 = 2 * XLEN;
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state_q, state_d;
  logic [XLEN-1:0] op_a, op_b, alu_res, md_res, q_mag, r_mag;
  logic [CW-1:0] shamt;
  logic stall, in_ready, accept, md_go, load_md, load_alu, last, busy;
  logic [W2-1:0] acc_q, acc_d, opa_q, opa_d, addend;
  logic [XLEN-1:0] opb_q, opb_d;
  logic [XLEN:0] rs, diff;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] op_q, op_d;
  logic msign_q, msign_d, negq_q, negq_d, negr_q, negr_d, div0_q, div0_d;
  logic a_neg, b_neg, sgn_div, a_sx;
  logic [XLEN-1:0] pc_q, pc_d, rs2_q, rs2_d, instr_q, instr_d;
  logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
  logic mem_valid_q, mem_valid_d;
  logic [XLEN-1:0] pc_mem_q, pc_mem_d, alu_mem_q, alu_mem_d, rs2_mem_q, rs2_mem_d, instr_mem_q, instr_mem_d;
  logic [REG_ADDR_WIDTH-1:0] rd_mem_q, rd_mem_d;
  always_comb begin
    op_a = bus.a_sel == 3'd0 ? bus.rs1_exe : bus.a_sel == 3'd1 ? bus.pc_exe :
           bus.a_sel == 3'd2 ? bus.forward_mem : bus.a_sel == 3'd3 ? bus.forward_wb : '0;
    op_b = bus.b_sel == 3'd0 ? bus.rs2_exe : bus.b_sel == 3'd1 ? bus.imm_exe :
           bus.b_sel == 3'd2 ? XLEN'(4) : bus.b_sel == 3'd3 ? bus.forward_mem :
           bus.b_sel == 3'd4 ? bus.forward_wb : '0;
  end
  assign shamt = op_b[CW-1:0];
  always_comb begin
    case (bus.alu_op)
      4'd0:    alu_res = op_a + op_b;
      4'd1:    alu_res = op_a - op_b;
      4'd2:    alu_res = op_a << shamt;
      4'd3:    alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      4'd4:    alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
      4'd5:    alu_res = op_a ^ op_b;
      4'd6:    alu_res = op_a >> shamt;
      4'd7:    alu_res = $signed(op_a) >>> shamt;
      4'd8:    alu_res = op_a | op_b;
      4'd9:    alu_res = op_a & op_b;
      4'd10:   alu_res = op_b;
      default: alu_res = '0;
    endcase
  end
  // FSM output/handshake decode
  always_comb begin
    stall    = mem_valid_q && !bus.mem_ready;
    in_ready = state_q == IDLE && !stall && !bus.flush;
    accept   = bus.in_valid && in_ready;
    md_go    = accept && MD_EN != 0 && bus.md_en;
    load_alu = accept && !md_go;
    load_md  = state_q == DONE && !stall && !bus.flush;
    last     = cnt_q == CW'(XLEN - 1);
    busy     = state_q != IDLE;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     state_d = md_go ? (bus.md_op[2] ? DIV : MUL) : IDLE;
      MUL, DIV: state_d = last ? DONE : state_q;
      DONE:     state_d = stall ? DONE : IDLE;
      default:  state_d = IDLE;
    endcase
    if (bus.flush) state_d = IDLE;
  end
  always_comb begin
    acc_d = acc_q;
    opa_d = opa_q;
    opb_d = opb_q;
    cnt_d = cnt_q;
    op_d = op_q;
    msign_d = msign_q;
    negq_d = negq_q;
    negr_d = negr_q;
    div0_d = div0_q;
    pc_d = pc_q;
    rs2_d = rs2_q;
    instr_d = instr_q;
    rd_d = rd_q;
    sgn_div = !bus.md_op[0];
    a_neg = op_a[XLEN-1];
    b_neg = op_b[XLEN-1];
    a_sx = bus.md_op == 3'd1 || bus.md_op == 3'd2;
    addend = opb_q[0] ? opa_q : '0;
    rs = {acc_q[XLEN-1:0], opa_q[XLEN-1]};
    diff = rs - {1'b0, opb_q};
    if (md_go) begin
      pc_d = bus.pc_exe;
      rs2_d = bus.rs2_exe;
      instr_d = bus.instr_exe;
      rd_d = bus.rd_addr_exe;
      op_d = bus.md_op;
      cnt_d = '0;
      acc_d = '0;
      opa_d = bus.md_op[2] ? {{XLEN{1'b0}}, sgn_div && a_neg ? -op_a : op_a} : {{XLEN{a_sx && a_neg}}, op_a};
      opb_d = bus.md_op[2] && sgn_div && b_neg ? -op_b : op_b;
      msign_d = bus.md_op == 3'd1;
      negq_d = bus.md_op[2] && sgn_div && (a_neg ^ b_neg);
      negr_d = bus.md_op[2] && sgn_div && a_neg;
      div0_d = bus.md_op[2] && op_b == '0;
    end else if (state_q == MUL) begin
      // signed multiplier: the MSB carries negative weight, so the last step subtracts
      acc_d = last && msign_q ? acc_q - addend : acc_q + addend;
      opa_d = opa_q << 1;
      opb_d = opb_q >> 1;
      cnt_d = cnt_q + CW'(1);
    end else if (state_q == DIV) begin
      acc_d = {{(XLEN-1){1'b0}}, diff[XLEN] ? rs : diff};
      opa_d = {opa_q[W2-2:0], !diff[XLEN]};
      cnt_d = cnt_q + CW'(1);
    end
  end
  // quotient magnitude of 2^(XLEN-1) with no sign flip yields the overflow result directly
  always_comb begin
    q_mag = opa_q[XLEN-1:0];
    r_mag = acc_q[XLEN-1:0];
    md_res = !op_q[2] ? (op_q[1:0] == 2'd0 ? acc_q[XLEN-1:0] : acc_q[W2-1:XLEN]) :
             op_q[1] ? (negr_q ? -r_mag : r_mag) :
             div0_q ? '1 : negq_q ? -q_mag : q_mag;
  end
  always_comb begin
    mem_valid_d = !bus.flush && (load_alu || load_md || stall);
    alu_mem_d = load_md ? md_res : load_alu ? alu_res : alu_mem_q;
    pc_mem_d = load_md ? pc_q : load_alu ? bus.pc_exe : pc_mem_q;
    rs2_mem_d = load_md ? rs2_q : load_alu ? bus.rs2_exe : rs2_mem_q;
    instr_mem_d = load_md ? instr_q : load_alu ? bus.instr_exe : instr_mem_q;
    rd_mem_d = load_md ? rd_q : load_alu ? bus.rd_addr_exe : rd_mem_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      opa_q <= '0;
      opb_q <= '0;
      cnt_q <= '0;
      op_q <= '0;
      msign_q <= 1'b0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
      div0_q <= 1'b0;
      pc_q <= '0;
      rs2_q <= '0;
      instr_q <= '0;
      rd_q <= '0;
      mem_valid_q <= 1'b0;
      alu_mem_q <= '0;
      pc_mem_q <= '0;
      rs2_mem_q <= '0;
      instr_mem_q <= '0;
      rd_mem_q <= '0;
    end else begin
      acc_q <= acc_d;
      opa_q <= opa_d;
      opb_q <= opb_d;
      cnt_q <= cnt_d;
      op_q <= op_d;
      msign_q <= msign_d;
      negq_q <= negq_d;
      negr_q <= negr_d;
      div0_q <= div0_d;
      pc_q <= pc_d;
      rs2_q <= rs2_d;
      instr_q <= instr_d;
      rd_q <= rd_d;
      mem_valid_q <= mem_valid_d;
      alu_mem_q <= alu_mem_d;
      pc_mem_q <= pc_mem_d;
      rs2_mem_q <= rs2_mem_d;
      instr_mem_q <= instr_mem_d;
      rd_mem_q <= rd_mem_d;
    end
  end
  assign bus.in_ready = in_ready;
  assign bus.busy = busy;
  assign bus.mem_valid = mem_valid_q;
  assign bus.alu_mem = alu_mem_q;
  assign bus.pc_mem = pc_mem_q;
  assign bus.rs2_mem = rs2_mem_q;
  assign bus.instr_mem = instr_mem_q;
  assign bus.rd_addr_mem = rd_mem_q;
endmodule
